// File: rtl/pitch_frame_sequencer.sv
// Frame sequencer for the autocorrelation pitch path: FILL -> CORR -> FIND -> PUB per frame.
// Define CORR_TIMEOUT_EN to build the CORR watchdog (sticky corr_timeout, pitch forced to 0).
module pitch_frame_sequencer #(
    parameter int unsigned FRAME_LEN    = 480,
    parameter int unsigned SAMPLE_W     = 24,
    parameter int unsigned LAG_MIN      = 47,
    parameter int unsigned LAG_MAX      = 141,
    parameter int unsigned FIND_SLACK   = 2,
    parameter int unsigned PITCH_W      = 14
`ifdef CORR_TIMEOUT_EN
    ,
    parameter int unsigned CORR_TIMEOUT = 4096
`endif
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                enable,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_in,
    output logic                sample_ready,
    output logic                buf_we,
    output logic [8:0]          buf_addr,
    output logic [SAMPLE_W-1:0] buf_data,
    output logic                corr_start,
    input  logic                corr_done,
    output logic                find_en,
    input  logic [PITCH_W-1:0]  pitch_in,
    output logic [PITCH_W-1:0]  pitch_out,
    output logic                pitch_valid,
    output logic                busy,
    output logic [15:0]         frame_cnt,
    output logic                corr_timeout
);

    localparam int unsigned NFIND  = (LAG_MAX - LAG_MIN + 1) + FIND_SLACK;
    localparam int unsigned FIND_W = $clog2(NFIND);

    typedef enum logic [2:0] {StIdle, StFill, StCorr, StFind, StPub} state_e;

    state_e              state_q, state_d;
    logic [8:0]          cnt_q, cnt_d;
    logic [FIND_W-1:0]   find_q, find_d;
    logic                corr_first_q;
    logic                buf_we_q;
    logic [8:0]          buf_addr_q;
    logic [SAMPLE_W-1:0] buf_data_q;
    logic [PITCH_W-1:0]  pitch_q;
    logic [PITCH_W-1:0]  pub_pitch;
    logic                pitch_valid_q;
    logic [15:0]         frame_cnt_q;
    logic                accept;
    logic                done_seen;
    logic                to_hit;

    // corr_done is ignored in the cycle corr_start is issued
    assign done_seen = (state_q == StCorr) && !corr_first_q && corr_done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        find_d  = find_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StFill;
                    cnt_d   = '0;
                end
            end
            StFill: begin
                accept = sample_valid;
                if (sample_valid) begin
                    cnt_d = cnt_q + 9'd1;
                    if (cnt_q == 9'(FRAME_LEN - 1)) begin
                        state_d = StCorr;
                    end
                end
            end
            StCorr: begin
                find_d = '0;
                if (done_seen) begin
                    state_d = StFind;
                end else if (to_hit) begin
                    state_d = StPub;
                end
            end
            StFind: begin
                find_d = find_q + FIND_W'(1);
                if (find_q == FIND_W'(NFIND - 1)) begin
                    state_d = StPub;
                end
            end
            StPub: begin
                state_d = enable ? StFill : StIdle;
                cnt_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            find_q        <= '0;
            corr_first_q  <= 1'b0;
            buf_we_q      <= 1'b0;
            buf_addr_q    <= '0;
            buf_data_q    <= '0;
            pitch_q       <= '0;
            pitch_valid_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            find_q       <= find_d;
            corr_first_q <= (state_q == StFill) && (state_d == StCorr);
            buf_we_q     <= accept;
            if (accept) begin
                buf_addr_q <= cnt_q;
                buf_data_q <= sample_in;
            end
            pitch_valid_q <= (state_q == StPub);
            if (state_q == StPub) begin
                pitch_q     <= pub_pitch;
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

`ifdef CORR_TIMEOUT_EN
    localparam int unsigned CW = $clog2(CORR_TIMEOUT);

    logic [CW-1:0] corr_cyc_q;
    logic          timeout_q;
    logic          to_frame_q;

    assign to_hit = (state_q == StCorr) && !done_seen && (corr_cyc_q == CW'(CORR_TIMEOUT - 1));

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            corr_cyc_q <= '0;
            timeout_q  <= 1'b0;
            to_frame_q <= 1'b0;
        end else begin
            corr_cyc_q <= (state_q == StCorr) ? corr_cyc_q + CW'(1) : '0;
            if (to_hit) begin
                timeout_q  <= 1'b1;
                to_frame_q <= 1'b1;
            end else if (state_q == StPub) begin
                to_frame_q <= 1'b0;
            end
        end
    end

    assign corr_timeout = timeout_q;
    assign pub_pitch    = to_frame_q ? '0 : pitch_in;
`else
    assign to_hit       = 1'b0;
    assign corr_timeout = 1'b0;
    assign pub_pitch    = pitch_in;
`endif

    assign sample_ready = (state_q == StFill);
    assign corr_start   = (state_q == StCorr) && corr_first_q;
    assign find_en      = (state_q == StFind);
    assign busy         = (state_q != StIdle);
    assign buf_we       = buf_we_q;
    assign buf_addr     = buf_addr_q;
    assign buf_data     = buf_data_q;
    assign pitch_out    = pitch_q;
    assign pitch_valid  = pitch_valid_q;
    assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_pitch_frame_sequencer.sv
// Scoreboard bench for pitch_frame_sequencer with a behavioural lag max-finder model.
`timescale 1ns/1ps
module tb_pitch_frame_sequencer;

    localparam int SAMPLE_W  = 24;
    localparam int PITCH_W   = 14;
    localparam int FRAME_LEN = 480;
    localparam int LAG_MIN   = 47;
    localparam int LAG_MAX   = 141;
    localparam int NFIND     = 97;

    logic                Clk = 1'b0;
    logic                Reset_n = 1'b0;
    logic                enable = 1'b0;
    logic                sample_valid = 1'b0;
    logic [SAMPLE_W-1:0] sample_in = '0;
    logic                corr_done = 1'b0;
    logic [PITCH_W-1:0]  pitch_in;
    logic                sample_ready, buf_we, corr_start, find_en, pitch_valid, busy;
    logic                corr_timeout;
    logic [8:0]          buf_addr;
    logic [SAMPLE_W-1:0] buf_data;
    logic [PITCH_W-1:0]  pitch_out;
    logic [15:0]         frame_cnt;

    int n_vec = 0;
    int n_err = 0;
    int frames_done = 0;
    int peak_lag = 100;
    logic [32:0]        wr_q[$];
    logic [PITCH_W-1:0] pitch_q[$];

    always #5 Clk = ~Clk;

    pitch_frame_sequencer dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .sample_ready (sample_ready),
        .buf_we       (buf_we),
        .buf_addr     (buf_addr),
        .buf_data     (buf_data),
        .corr_start   (corr_start),
        .corr_done    (corr_done),
        .find_en      (find_en),
        .pitch_in     (pitch_in),
        .pitch_out    (pitch_out),
        .pitch_valid  (pitch_valid),
        .busy         (busy),
        .frame_cnt    (frame_cnt),
        .corr_timeout (corr_timeout)
    );

    // Finder model: one lag per find_en cycle, correlation peaks at peak_lag.
    int f_idx = 0;
    int best_lag = LAG_MIN;
    int best_val = -1;

    function automatic int corr_val(input int lag);
        int d;
        d = lag - peak_lag;
        if (d < 0) d = -d;
        return 1000 - d;
    endfunction

    always @(posedge Clk) begin
        if (!find_en) begin
            f_idx    <= 0;
            best_val <= -1;
            best_lag <= LAG_MIN;
        end else begin
            f_idx <= f_idx + 1;
            if ((LAG_MIN + f_idx <= LAG_MAX) && (corr_val(LAG_MIN + f_idx) > best_val)) begin
                best_val <= corr_val(LAG_MIN + f_idx);
                best_lag <= LAG_MIN + f_idx;
            end
        end
    end

    assign pitch_in = PITCH_W'(12000 / best_lag);

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic fill(input int n);
        logic [32:0] exp;
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            sample_in    = SAMPLE_W'($urandom);
            n_vec++;
            if (sample_ready !== 1'b1) begin
                n_err++;
                $display("FAIL fill_ready[%0d]: got %b want 1", i, sample_ready);
            end
            wr_q.push_back({9'(i), sample_in});
            step();
            exp = wr_q.pop_front();
            n_vec++;
            if (buf_we !== 1'b1 || {buf_addr, buf_data} !== exp) begin
                n_err++;
                $display("FAIL buf_write[%0d]: got we=%b addr=%0d data=%h want we=1 addr=%0d data=%h",
                         i, buf_we, buf_addr, buf_data, exp[32:24], exp[23:0]);
            end
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        repeat (3) step();
        n_vec++;
        if ({busy, sample_ready, buf_we, buf_addr, buf_data, corr_start, find_en, pitch_out,
             pitch_valid, frame_cnt, corr_timeout} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b we=%b addr=%0d pitch=%0d frames=%0d want all 0",
                     busy, buf_we, buf_addr, pitch_out, frame_cnt);
        end
        Reset_n = 1'b1;
        step();
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_mid_fill();
        enable = 1'b1;
        step();
        fill(100);
        Reset_n = 1'b0;
        enable  = 1'b0;
        sample_valid = 1'b0;
        step();
        n_vec++;
        if ({busy, sample_ready, buf_we, buf_addr, buf_data, corr_start, find_en, pitch_valid,
             frame_cnt} !== '0) begin
            n_err++;
            $display("FAIL reset_mid_fill: got busy=%b ready=%b we=%b addr=%0d want all 0",
                     busy, sample_ready, buf_we, buf_addr);
        end
        Reset_n = 1'b1;
        step();
    endtask

    // Starts with the DUT in FILL; en_after is applied to enable partway through FIND.
    task automatic run_frame(input bit en_after, input int done_delay, input int peak);
        int steps;
        int cnt;
        int stray;
        logic [PITCH_W-1:0] exp_pitch;
        peak_lag = peak;
        pitch_q.push_back(PITCH_W'(12000 / peak));
        fill(FRAME_LEN);
        n_vec++;
        if (sample_ready !== 1'b0 || corr_start !== 1'b1) begin
            n_err++;
            $display("FAIL corr_entry: got ready=%b start=%b want ready=0 start=1",
                     sample_ready, corr_start);
        end
        corr_done = (done_delay == 0);
        step();
        n_vec++;
        if (corr_start !== 1'b0 || find_en !== 1'b0) begin
            n_err++;
            $display("FAIL corr_pulse: got start=%b find_en=%b want 0 0", corr_start, find_en);
        end
        steps = 0;
        while (find_en !== 1'b1 && steps < 64) begin
            if (steps + 2 >= 1 + done_delay) corr_done = 1'b1;
            step();
            steps++;
        end
        n_vec++;
        if (steps != ((done_delay > 1) ? done_delay : 1)) begin
            n_err++;
            $display("FAIL corr_latency: got %0d cycles want %0d", steps,
                     (done_delay > 1) ? done_delay : 1);
        end
        cnt = 0;
        stray = 0;
        while (find_en === 1'b1 && cnt < 200) begin
            if (cnt == 40) enable = en_after;
            if (buf_we !== 1'b0) stray++;
            step();
            cnt++;
        end
        n_vec++;
        if (cnt != NFIND || stray != 0) begin
            n_err++;
            $display("FAIL find_window: got %0d cycles (%0d stray writes) want %0d cycles 0 writes",
                     cnt, stray, NFIND);
        end
        n_vec++;
        if (busy !== 1'b1 || pitch_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pub_state: got busy=%b valid=%b want 1 0", busy, pitch_valid);
        end
        corr_done = 1'b0;
        sample_valid = 1'b0;
        frames_done++;
        step();
        exp_pitch = pitch_q.pop_front();
        n_vec++;
        if (pitch_valid !== 1'b1 || pitch_out !== exp_pitch || frame_cnt !== 16'(frames_done)) begin
            n_err++;
            $display("FAIL publish: got valid=%b pitch=%0d frames=%0d want 1 %0d %0d",
                     pitch_valid, pitch_out, frame_cnt, exp_pitch, frames_done);
        end
        n_vec++;
        if (sample_ready !== en_after || busy !== en_after) begin
            n_err++;
            $display("FAIL after_pub: got ready=%b busy=%b want %b %b",
                     sample_ready, busy, en_after, en_after);
        end
        step();
        n_vec++;
        if (pitch_valid !== 1'b0 || pitch_out !== exp_pitch) begin
            n_err++;
            $display("FAIL pitch_hold: got valid=%b pitch=%0d want 0 %0d",
                     pitch_valid, pitch_out, exp_pitch);
        end
    endtask

    task automatic test_stray_done();
        int bad;
        bad = 0;
        corr_done = 1'b1;
        repeat (5) begin
            step();
            if (busy !== 1'b0 || corr_start !== 1'b0 || find_en !== 1'b0) bad++;
        end
        corr_done = 1'b0;
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL stray_done_idle: got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_corr_hang();
        int steps;
        int bad;
        enable = 1'b1;
        step();
        fill(FRAME_LEN);
        enable = 1'b0;
        sample_valid = 1'b0;
        corr_done = 1'b0;
`ifdef CORR_TIMEOUT_EN
        steps = 0;
        bad = 0;
        while (pitch_valid !== 1'b1 && steps < 5000) begin
            if (find_en !== 1'b0) bad++;
            step();
            steps++;
        end
        frames_done++;
        n_vec++;
        if (steps != 4097 || bad != 0) begin
            n_err++;
            $display("FAIL timeout_latency: got %0d cycles (%0d find) want 4097 0", steps, bad);
        end
        n_vec++;
        if (corr_timeout !== 1'b1 || pitch_out !== '0 || frame_cnt !== 16'(frames_done)) begin
            n_err++;
            $display("FAIL timeout_publish: got flag=%b pitch=%0d frames=%0d want 1 0 %0d",
                     corr_timeout, pitch_out, frame_cnt, frames_done);
        end
`else
        bad = 0;
        for (steps = 0; steps < 4200; steps++) begin
            if (busy !== 1'b1 || find_en !== 1'b0 || pitch_valid !== 1'b0 || corr_timeout !== 1'b0)
                bad++;
            step();
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL corr_wait: got %0d cycles outside CORR want 0", bad);
        end
`endif
        Reset_n = 1'b0;
        step();
        Reset_n = 1'b1;
        n_vec++;
        if (busy !== 1'b0 || corr_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_after_hang: got busy=%b flag=%b want 0 0", busy, corr_timeout);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_fill();
        enable = 1'b1;
        step();
        run_frame(1'b1, 0, 100);
        run_frame(1'b1, 5, 60);
        run_frame(1'b1, 1, LAG_MIN);
        run_frame(1'b0, 3, LAG_MAX);
        test_stray_done();
        test_corr_hang();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
